proto_tx_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one serial protocol link among `N_REQ` requesters. Grants one requester at a time, latches its word, and drives the IDLE/SEND/WAIT/DONE transaction: start bit plus MSB-first data on `tx_out`, then an acknowledge wait with timeout. Per-requester completion or error is reported back. Sits between client blocks and the link-level protocol pins.

---
 rtl/proto_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/proto_tx_arbiter.sv
// proto_tx_arbiter
// Round-robin arbiter plus serial transaction sequencer for one shared link.
// A granted requester's word is sent as a start bit followed by the data,
// MSB first. The block then waits a bounded time for rx_ack and reports
// done or err back to that requester.
module proto_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    output logic                      tx_out,
    input  logic                      rx_ack,
    output logic                      busy
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // Last SEND slot (slot 0 is the start bit) and last WAIT count before timeout.
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [IDX_W-1:0]    r_winner;
    logic [IDX_W-1:0]    r_ptr;
    logic [DATA_W-1:0]   r_shift;
    logic                r_ack_ok;

    logic                w_any;
    int                  w_win_idx;
    logic [IDX_W-1:0]    w_winner;

    // Round-robin search: the requester at the smallest offset from r_ptr wins.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 0;
        // Walking downward means the last hit, which is the smallest offset, is kept.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % N_REQ]) begin
                w_any     = 1'b1;
                w_win_idx = (int'(r_ptr) + i) % N_REQ;
            end
        end
    end

    assign w_winner = IDX_W'(w_win_idx);
    assign busy     = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, whatever order the statements are in.
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves
        // one unassigned and no latch is inferred.
        w_next_state = r_state;
        gnt          = '0;
        done         = '0;
        err          = '0;
        tx_out       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Grant is gated by rstn so that asserting reset drops it at once.
                if (w_any && rstn) begin
                    gnt[w_winner] = 1'b1;
                    w_next_state  = S_SEND;
                end
            end
            S_SEND: begin
                tx_out = (r_bit_cnt == '0) ? 1'b1 : r_shift[DATA_W-1];
                if (r_bit_cnt == LAST_BIT) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_ack || (r_wait_cnt == LAST_WAIT)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done[r_winner] = r_ack_ok;
                err[r_winner]  = ~r_ack_ok;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the winner, shift data out, count wait cycles, move the pointer.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the latched data word is cleared on reset along with the control
        // registers, so nothing left over from an aborted transaction stays visible.
        if (!rstn) begin
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_winner   <= '0;
            r_ptr      <= '0;
            r_shift    <= '0;
            r_ack_ok   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_shift   <= data[w_win_idx*DATA_W +: DATA_W];
                        r_winner  <= w_winner;
                        r_bit_cnt <= '0;
                    end
                end
                S_SEND: begin
                    // The start-bit slot leaves the word in place so its MSB is next.
                    if (r_bit_cnt != '0) begin
                        r_shift <= r_shift << 1;
                    end
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (rx_ack) begin
                        r_ack_ok <= 1'b1;
                    end else if (r_wait_cnt == LAST_WAIT) begin
                        r_ack_ok <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr      <= IDX_W'((int'(r_winner) + 1) % N_REQ);
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_bit_cnt  <= '0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
